// File: rtl/abstract_cmd_encoder.sv
// Debug-side abstract command encoder: emits a short RISC-V instruction
// sequence (ending in EBREAK) for a GPR/CSR read or write request.
// Ports:
//   clk_i, rst_i (sync, active high), flush_i
//   req_valid_i/req_ready_o, req_op_i, req_regno_i, req_size64_i : command in
//   instr_valid_o/instr_ready_i, instr_o                         : word stream out
//   busy_o, done_o, err_o                                        : status
module abstract_cmd_encoder #(
    parameter int          XLEN      = 64,
    parameter logic [11:0] DATA_ADDR = 12'h380,
    parameter logic [11:0] SCRATCH   = 12'h7B2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [1:0]  req_op_i,
    input  logic [11:0] req_regno_i,
    input  logic        req_size64_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    typedef enum logic [1:0] {IDLE, EMIT, DONE} state_e;

    localparam logic [1:0]  OP_GPR_RD = 2'b00;
    localparam logic [1:0]  OP_GPR_WR = 2'b01;
    localparam logic [1:0]  OP_CSR_RD = 2'b10;
    localparam logic [1:0]  OP_CSR_WR = 2'b11;
    localparam logic [4:0]  S0        = 5'd8;
    localparam logic [4:0]  X0        = 5'd0;
    localparam logic [31:0] EBREAK    = 32'h00100073;

    state_e      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [1:0]  op_q, op_d;
    logic [11:0] regno_q, regno_d;
    logic        s64_q, s64_d;
    logic        err_q, err_d;

    logic        accept;
    logic        reject;
    logic        instr_hs;
    logic [2:0]  last_idx;
    logic [2:0]  f3_ls;
    logic [31:0] word;

    function automatic logic [31:0] enc_store(logic [4:0] rs2, logic [2:0] f3);
        return {DATA_ADDR[11:5], rs2, X0, f3, DATA_ADDR[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_load(logic [4:0] rd, logic [2:0] f3);
        return {DATA_ADDR, X0, f3, rd, 7'b0000011};
    endfunction

    function automatic logic [31:0] enc_csr(logic [11:0] csr, logic [4:0] rs1,
                                            logic [2:0] f3, logic [4:0] rd);
        return {csr, rs1, f3, rd, 7'b1110011};
    endfunction

    // flush blocks acceptance even though ready is still shown in IDLE
    assign accept   = req_valid_i && req_ready_o && !flush_i;
    assign reject   = req_size64_i && (XLEN == 32);
    assign instr_hs = instr_valid_o && instr_ready_i;
    assign last_idx = op_q[1] ? 3'd4 : 3'd1;
    assign f3_ls    = s64_q ? 3'b011 : 3'b010;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            op_q    <= 2'b00;
            regno_q <= 12'd0;
            s64_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            op_q    <= op_d;
            regno_q <= regno_d;
            s64_q   <= s64_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        op_d    = op_q;
        regno_d = regno_q;
        s64_d   = s64_q;
        err_d   = 1'b0;
        if (flush_i) begin
            state_d = IDLE;
            idx_d   = 3'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (reject) begin
                            err_d = 1'b1;
                        end else begin
                            op_d    = req_op_i;
                            regno_d = req_regno_i;
                            s64_d   = req_size64_i;
                            idx_d   = 3'd0;
                            state_d = EMIT;
                        end
                    end
                end
                EMIT: begin
                    if (instr_hs) begin
                        if (idx_q == last_idx) begin
                            idx_d   = 3'd0;
                            state_d = DONE;
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // word table; CSR sequences bracket the access with an s0 save/restore
    always_comb begin
        word = EBREAK;
        unique case (op_q)
            OP_GPR_RD: if (idx_q == 3'd0) word = enc_store(regno_q[4:0], f3_ls);
            OP_GPR_WR: if (idx_q == 3'd0) word = enc_load(regno_q[4:0], f3_ls);
            OP_CSR_RD: begin
                unique case (idx_q)
                    3'd0:    word = enc_csr(SCRATCH, S0, 3'b001, X0);
                    3'd1:    word = enc_csr(regno_q, X0, 3'b010, S0);
                    3'd2:    word = enc_store(S0, f3_ls);
                    3'd3:    word = enc_csr(SCRATCH, X0, 3'b010, S0);
                    default: word = EBREAK;
                endcase
            end
            OP_CSR_WR: begin
                unique case (idx_q)
                    3'd0:    word = enc_csr(SCRATCH, S0, 3'b001, X0);
                    3'd1:    word = enc_load(S0, f3_ls);
                    3'd2:    word = enc_csr(regno_q, S0, 3'b001, X0);
                    3'd3:    word = enc_csr(SCRATCH, X0, 3'b010, S0);
                    default: word = EBREAK;
                endcase
            end
            default: word = EBREAK;
        endcase
    end

    always_comb begin
        req_ready_o   = (state_q == IDLE);
        instr_valid_o = (state_q == EMIT);
        instr_o       = (state_q == EMIT) ? word : 32'd0;
        busy_o        = (state_q != IDLE);
        done_o        = (state_q == DONE);
        err_o         = err_q;
    end

endmodule

// File: tb/tb_abstract_cmd_encoder.sv
// Scoreboard bench for abstract_cmd_encoder: expected words queued at issue,
// monitor pops on each instruction handshake.
module tb_abstract_cmd_encoder;

    localparam logic [31:0] EBRK = 32'h00100073;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [11:0] req_regno;
    logic        req_s64;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic        busy;
    logic        done;
    logic        err;

    logic        r32_valid;
    logic        r32_ready;
    logic [1:0]  r32_op;
    logic [11:0] r32_regno;
    logic        r32_s64;
    logic        r32_ivalid;
    logic        r32_iready;
    logic [31:0] r32_instr;
    logic        r32_busy;
    logic        r32_done;
    logic        r32_err;
    logic        r32_flush;

    abstract_cmd_encoder #(.XLEN(64)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_op_i(req_op), .req_regno_i(req_regno), .req_size64_i(req_s64),
        .instr_valid_o(instr_valid), .instr_ready_i(instr_ready),
        .instr_o(instr), .busy_o(busy), .done_o(done), .err_o(err)
    );

    abstract_cmd_encoder #(.XLEN(32)) dut32 (
        .clk_i(clk), .rst_i(rst), .flush_i(r32_flush),
        .req_valid_i(r32_valid), .req_ready_o(r32_ready),
        .req_op_i(r32_op), .req_regno_i(r32_regno), .req_size64_i(r32_s64),
        .instr_valid_o(r32_ivalid), .instr_ready_i(r32_iready),
        .instr_o(r32_instr), .busy_o(r32_busy), .done_o(r32_done), .err_o(r32_err)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    int          done_exp = 0;
    int          done_seen = 0;
    logic        mon_en = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_word = 32'd0;
    logic        prev_ebrk_hs = 1'b0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            logic hs;
            hs = instr_valid && instr_ready;
            if (instr_valid && prev_stall) chk("hold_stable", instr, prev_word);
            if (instr_valid) chk("busy_with_valid", {31'd0, busy}, 32'd1);
            if (done) begin
                done_seen++;
                chk("done_after_ebreak", {31'd0, prev_ebrk_hs}, 32'd1);
                chk("done_no_valid", {31'd0, instr_valid}, 32'd0);
            end
            if (err) begin
                checks++;
                errors++;
                $display("FAIL err64 got 1 want 0");
            end
            if (hs) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word got %h want none", instr);
                end else begin
                    chk("word", instr, exp_q.pop_front());
                end
            end
            prev_stall   = instr_valid && !instr_ready;
            prev_word    = instr;
            prev_ebrk_hs = hs && (instr == EBRK);
        end
    end

    task automatic issue(logic [1:0] op, logic [11:0] regno, logic s64);
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_op    = op;
        req_regno = regno;
        req_s64   = s64;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = ~op;
        req_regno = 12'hFFF;
        req_s64   = ~s64;
    endtask

    task automatic wait_idle(string name);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout got busy want idle", name);
        end
        @(negedge clk);
        chk({name, "_done_cnt"}, done_seen, done_exp);
    endtask

    initial begin
        rst         = 1'b1;
        flush       = 1'b0;
        req_valid   = 1'b0;
        req_op      = 2'b00;
        req_regno   = 12'd0;
        req_s64     = 1'b0;
        instr_ready = 1'b1;
        r32_valid   = 1'b0;
        r32_op      = 2'b00;
        r32_regno   = 12'd0;
        r32_s64     = 1'b0;
        r32_iready  = 1'b1;
        r32_flush   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        mon_en = 1'b1;

        // GPR_RD x5, 32-bit, full throughput
        exp_q.push_back(32'h38502023);
        exp_q.push_back(EBRK);
        done_exp++;
        issue(2'b00, 12'd5, 1'b0);
        wait_idle("gpr_rd");

        // GPR_WR x5 with consumer stalled on word0
        instr_ready = 1'b0;
        exp_q.push_back(32'h38002283);
        exp_q.push_back(EBRK);
        done_exp++;
        issue(2'b01, 12'd5, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        instr_ready = 1'b1;
        wait_idle("gpr_wr_stall");

        // CSR_RD mstatus
        exp_q.push_back(32'h7B241073);
        exp_q.push_back(32'h30002473);
        exp_q.push_back(32'h38802023);
        exp_q.push_back(32'h7B202473);
        exp_q.push_back(EBRK);
        done_exp++;
        issue(2'b10, 12'h300, 1'b0);
        wait_idle("csr_rd");

        // 64-bit GPR_RD accepted on XLEN=64
        exp_q.push_back(32'h38503023);
        exp_q.push_back(EBRK);
        done_exp++;
        issue(2'b00, 12'd5, 1'b1);
        wait_idle("gpr_rd64");

        // CSR_WR mstatus
        exp_q.push_back(32'h7B241073);
        exp_q.push_back(32'h38002403);
        exp_q.push_back(32'h30041073);
        exp_q.push_back(32'h7B202473);
        exp_q.push_back(EBRK);
        done_exp++;
        issue(2'b11, 12'h300, 1'b0);
        wait_idle("csr_wr");

        // CSR_WR flushed while word2 is presented
        exp_q.push_back(32'h7B241073);
        exp_q.push_back(32'h38002403);
        exp_q.push_back(32'h30041073);
        exp_q.push_back(32'h7B202473);
        exp_q.push_back(EBRK);
        issue(2'b11, 12'h300, 1'b0);
        begin
            int n = 0;
            while (exp_q.size() != 3 && n < 50) begin
                @(posedge clk);
                #1;
                n++;
            end
            if (n >= 50) begin
                checks++;
                errors++;
                $display("FAIL flush_reach_word2 got %0d want 3", exp_q.size());
            end
        end
        chk("flush_word2", instr, 32'h30041073);
        instr_ready = 1'b0;
        flush       = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        exp_q.delete();
        instr_ready = 1'b1;
        @(negedge clk);
        chk("flush_valid", {31'd0, instr_valid}, 32'd0);
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_done", {31'd0, done}, 32'd0);
        wait_idle("flush");

        // clean GPR_RD after flush, then x0 and x31 boundaries
        exp_q.push_back(32'h38502023);
        exp_q.push_back(EBRK);
        done_exp++;
        issue(2'b00, 12'd5, 1'b0);
        wait_idle("post_flush");

        exp_q.push_back(32'h38002023);
        exp_q.push_back(EBRK);
        done_exp++;
        issue(2'b00, 12'd0, 1'b0);
        wait_idle("gpr_rd_x0");

        exp_q.push_back(32'h38003F83);
        exp_q.push_back(EBRK);
        done_exp++;
        issue(2'b01, 12'd31, 1'b1);
        wait_idle("gpr_wr_x31");

        // request presented together with flush is ignored
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_op    = 2'b10;
        req_regno = 12'h300;
        flush     = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        flush     = 1'b0;
        @(negedge clk);
        chk("flush_req_busy", {31'd0, busy}, 32'd0);
        chk("flush_req_valid", {31'd0, instr_valid}, 32'd0);

        // XLEN=32 rejects 64-bit access
        @(posedge clk);
        #1;
        r32_valid = 1'b1;
        r32_op    = 2'b00;
        r32_regno = 12'd5;
        r32_s64   = 1'b1;
        @(posedge clk);
        #1;
        r32_valid = 1'b0;
        @(negedge clk);
        chk("x32_err", {31'd0, r32_err}, 32'd1);
        chk("x32_err_valid", {31'd0, r32_ivalid}, 32'd0);
        chk("x32_err_ready", {31'd0, r32_ready}, 32'd1);
        chk("x32_err_busy", {31'd0, r32_busy}, 32'd0);
        chk("x32_err_nodone", {31'd0, r32_done}, 32'd0);
        @(negedge clk);
        chk("x32_err_pulse", {31'd0, r32_err}, 32'd0);
        chk("x32_err_valid2", {31'd0, r32_ivalid}, 32'd0);

        // XLEN=32 still runs a 32-bit access
        @(posedge clk);
        #1;
        r32_valid = 1'b1;
        r32_s64   = 1'b0;
        @(posedge clk);
        #1;
        r32_valid = 1'b0;
        @(negedge clk);
        chk("x32_ok_err", {31'd0, r32_err}, 32'd0);
        chk("x32_ok_valid", {31'd0, r32_ivalid}, 32'd1);
        chk("x32_ok_word", r32_instr, 32'h38502023);

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("total_done", done_seen, done_exp);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
